combat_round_ctrl: RTL

Parametrised two-player combat and round manager; successor to the fixed-function health manager. Accepts per-player light/heavy attacks, hit-range and block flags, applies damage with cooldowns, and runs a best-of-N round state machine with a round timer. Sits between collision detection and the status-bar/sprite renderers, on the system clock, with game-tick enable.

---
 rtl/combat_pkg.sv | 29 ++
 rtl/combat_round_ctrl_if.sv | 42 ++++
 rtl/combat_round_ctrl_attack_channel.sv | 69 ++++++
 rtl/combat_round_ctrl.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/combat_pkg.sv
// Shared encodings for the combat round controller: round states, round
// winners, the round-timer width and the round-winner decision rule.
package combat_pkg;

  localparam int TIME_W = 11;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_FIGHT      = 2'd1,
    ST_KO         = 2'd2,
    ST_MATCH_OVER = 2'd3
  } round_state_e;

  typedef enum logic [1:0] {
    WIN_NONE = 2'd0,
    WIN_P1   = 2'd1,
    WIN_P2   = 2'd2,
    WIN_DRAW = 2'd3
  } winner_e;

  // A knocked-out player has zero health, so "higher health wins, equal is
  // a draw" covers both the KO and the timeout cases.
  function automatic winner_e decide_winner(input logic [31:0] h1, input logic [31:0] h2);
    if (h1 > h2)      return WIN_P1;
    else if (h2 > h1) return WIN_P2;
    else              return WIN_DRAW;
  endfunction

endpackage

// File: rtl/combat_round_ctrl_if.sv
// Player inputs and status outputs of the combat round controller.
// master = game logic / collision side, slave = the controller.
interface combat_round_ctrl_if #(
  parameter int HP_W = 9
);
  import combat_pkg::*;

  logic                tick;
  logic                start;
  logic                p1_light;
  logic                p1_heavy;
  logic                p2_light;
  logic                p2_heavy;
  logic                p1_in_range;
  logic                p2_in_range;
  logic                p1_block;
  logic                p2_block;
  logic [HP_W-1:0]     health_1;
  logic [HP_W-1:0]     health_2;
  logic [1:0]          cd_busy;
  logic [1:0]          hit_pulse;
  logic [1:0]          round_state;
  logic [1:0]          round_winner;
  logic [1:0]          wins_1;
  logic [1:0]          wins_2;
  logic [TIME_W-1:0]   time_left;

  modport master (
    output tick, start, p1_light, p1_heavy, p2_light, p2_heavy,
           p1_in_range, p2_in_range, p1_block, p2_block,
    input  health_1, health_2, cd_busy, hit_pulse, round_state,
           round_winner, wins_1, wins_2, time_left
  );

  modport slave (
    input  tick, start, p1_light, p1_heavy, p2_light, p2_heavy,
           p1_in_range, p2_in_range, p1_block, p2_block,
    output health_1, health_2, cd_busy, hit_pulse, round_state,
           round_winner, wins_1, wins_2, time_left
  );

endinterface

// File: rtl/combat_round_ctrl_attack_channel.sv
// One player's attack path: button edge detection, heavy-over-light
// priority, cooldown counter and damage selection with block halving.
module attack_channel #(
  parameter int HP_W      = 9,
  parameter int LIGHT_DMG = 10,
  parameter int HEAVY_DMG = 25,
  parameter int LIGHT_CD  = 4,
  parameter int HEAVY_CD  = 10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            tick,
  input  logic            enable,     // round is in FIGHT
  input  logic            clear,      // drop any running cooldown
  input  logic            light,
  input  logic            heavy,
  input  logic            in_range,
  input  logic            opp_block,
  output logic            busy,
  output logic            land,
  output logic [HP_W-1:0] dmg
);
  localparam int CD_MAX = (HEAVY_CD > LIGHT_CD) ? HEAVY_CD : LIGHT_CD;
  localparam int CD_W   = $clog2(CD_MAX + 1);

  logic            light_prev_reg, heavy_prev_reg, busy_reg;
  logic [CD_W-1:0] cd_reg, cd_next;
  logic            light_edge, heavy_edge, accept;
  logic [HP_W-1:0] base_dmg;

  // Press detection, acceptance, damage select and next cooldown value.
  always_comb begin
    light_edge = light & ~light_prev_reg;
    heavy_edge = heavy & ~heavy_prev_reg;
    accept     = tick & enable & (light_edge | heavy_edge) & (cd_reg == '0);
    land       = accept & in_range;
    base_dmg   = heavy_edge ? HP_W'(HEAVY_DMG) : HP_W'(LIGHT_DMG);
    dmg        = opp_block ? (base_dmg >> 1) : base_dmg;
    cd_next    = cd_reg;
    if (tick) begin
      if (clear)
        cd_next = '0;
      else if (accept)
        cd_next = heavy_edge ? CD_W'(HEAVY_CD) : CD_W'(LIGHT_CD);
      else if (cd_reg != '0)
        cd_next = cd_reg - CD_W'(1);
    end
  end

  // Edge history advances on ticks; busy is registered alongside the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      light_prev_reg <= 1'b0;
      heavy_prev_reg <= 1'b0;
      cd_reg         <= '0;
      busy_reg       <= 1'b0;
    end else begin
      cd_reg   <= cd_next;
      busy_reg <= (cd_next != '0);
      if (tick) begin
        light_prev_reg <= light;
        heavy_prev_reg <= heavy;
      end
    end
  end

  assign busy = busy_reg;

endmodule

// File: rtl/combat_round_ctrl.sv
// Two-player combat and round manager: health with saturation, round timer,
// best-of-N round FSM and win counters around two attack channels.
module combat_round_ctrl
  import combat_pkg::*;
#(
  parameter int MAX_HP      = 200,
  parameter int HP_W        = 9,
  parameter int LIGHT_DMG   = 10,
  parameter int HEAVY_DMG   = 25,
  parameter int LIGHT_CD    = 4,
  parameter int HEAVY_CD    = 10,
  parameter int ROUND_TICKS = 1200,
  parameter int KO_HOLD     = 40,
  parameter int WINS_NEEDED = 2
) (
  input  logic              clk,
  input  logic              reset,
  combat_round_ctrl_if.slave bus
);
  localparam logic [HP_W-1:0]   MAX_HP_V = HP_W'(MAX_HP);
  localparam logic [TIME_W-1:0] ROUND_V  = TIME_W'(ROUND_TICKS);
  localparam int                KO_W     = $clog2(KO_HOLD + 1);
  localparam logic [1:0]        WINS_V   = 2'(WINS_NEEDED);

  round_state_e    state_reg, state_next;
  winner_e         winner_reg, winner_next;
  logic [HP_W-1:0] health_1_reg, health_1_next, health_2_reg, health_2_next;
  logic [HP_W-1:0] h1_dmg, h2_dmg;
  logic [1:0]      wins_1_reg, wins_1_next, wins_2_reg, wins_2_next;
  logic [1:0]      hit_reg, hit_next;
  logic [TIME_W-1:0] time_left_reg, time_left_next, time_dec;
  logic [KO_W-1:0] ko_cnt_reg, ko_cnt_next;
  logic            clear_cd;

  // Per-player vectors, index 0 = P1. Channel gi attacks player 1-gi.
  logic [1:0]      light_v, heavy_v, range_v, block_v, busy_v, land_v;
  logic [HP_W-1:0] dmg_v [2];

  assign light_v = {bus.p2_light, bus.p1_light};
  assign heavy_v = {bus.p2_heavy, bus.p1_heavy};
  assign range_v = {bus.p2_in_range, bus.p1_in_range};
  assign block_v = {bus.p2_block, bus.p1_block};

  for (genvar gi = 0; gi < 2; gi++) begin : g_chan
    attack_channel #(
      .HP_W(HP_W), .LIGHT_DMG(LIGHT_DMG), .HEAVY_DMG(HEAVY_DMG),
      .LIGHT_CD(LIGHT_CD), .HEAVY_CD(HEAVY_CD)
    ) u_chan (
      .clk(clk), .reset(reset), .tick(bus.tick),
      .enable(state_reg == ST_FIGHT), .clear(clear_cd),
      .light(light_v[gi]), .heavy(heavy_v[gi]), .in_range(range_v[gi]),
      .opp_block(block_v[1-gi]),
      .busy(busy_v[gi]), .land(land_v[gi]), .dmg(dmg_v[gi])
    );
  end

  // Round FSM and datapath next-state: damage, timer, winner, KO hold.
  always_comb begin
    state_next     = state_reg;
    winner_next    = winner_reg;
    health_1_next  = health_1_reg;
    health_2_next  = health_2_reg;
    wins_1_next    = wins_1_reg;
    wins_2_next    = wins_2_reg;
    time_left_next = time_left_reg;
    ko_cnt_next    = ko_cnt_reg;
    hit_next       = 2'b00;
    clear_cd       = 1'b0;
    h1_dmg = !land_v[1] ? health_1_reg :
             (health_1_reg > dmg_v[1]) ? health_1_reg - dmg_v[1] : '0;
    h2_dmg = !land_v[0] ? health_2_reg :
             (health_2_reg > dmg_v[0]) ? health_2_reg - dmg_v[0] : '0;
    time_dec = time_left_reg - TIME_W'(1);
    if (bus.tick) begin
      case (state_reg)
        ST_IDLE: begin
          if (bus.start) begin
            state_next = ST_FIGHT;
            clear_cd   = 1'b1;
          end
        end
        ST_FIGHT: begin
          health_1_next  = h1_dmg;
          health_2_next  = h2_dmg;
          hit_next       = {land_v[0], land_v[1]};
          time_left_next = time_dec;
          if (h1_dmg == '0 || h2_dmg == '0 || time_dec == '0) begin
            state_next  = ST_KO;
            ko_cnt_next = KO_W'(KO_HOLD);
            winner_next = decide_winner(32'(h1_dmg), 32'(h2_dmg));
            if (winner_next == WIN_P1) wins_1_next = wins_1_reg + 2'd1;
            if (winner_next == WIN_P2) wins_2_next = wins_2_reg + 2'd1;
          end
        end
        ST_KO: begin
          if (ko_cnt_reg <= KO_W'(1)) begin
            if (wins_1_reg == WINS_V || wins_2_reg == WINS_V) begin
              state_next = ST_MATCH_OVER;
            end else begin
              state_next     = ST_FIGHT;
              health_1_next  = MAX_HP_V;
              health_2_next  = MAX_HP_V;
              time_left_next = ROUND_V;
              clear_cd       = 1'b1;
            end
          end else begin
            ko_cnt_next = ko_cnt_reg - KO_W'(1);
          end
        end
        default: begin  // ST_MATCH_OVER
          if (bus.start) begin
            state_next     = ST_IDLE;
            winner_next    = WIN_NONE;
            health_1_next  = MAX_HP_V;
            health_2_next  = MAX_HP_V;
            wins_1_next    = 2'd0;
            wins_2_next    = 2'd0;
            time_left_next = ROUND_V;
          end
        end
      endcase
    end
  end

  // State register; reset aborts any round straight to the idle values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      winner_reg    <= WIN_NONE;
      health_1_reg  <= MAX_HP_V;
      health_2_reg  <= MAX_HP_V;
      wins_1_reg    <= 2'd0;
      wins_2_reg    <= 2'd0;
      time_left_reg <= ROUND_V;
      ko_cnt_reg    <= '0;
      hit_reg       <= 2'b00;
    end else begin
      state_reg     <= state_next;
      winner_reg    <= winner_next;
      health_1_reg  <= health_1_next;
      health_2_reg  <= health_2_next;
      wins_1_reg    <= wins_1_next;
      wins_2_reg    <= wins_2_next;
      time_left_reg <= time_left_next;
      ko_cnt_reg    <= ko_cnt_next;
      hit_reg       <= hit_next;
    end
  end

  assign bus.health_1     = health_1_reg;
  assign bus.health_2     = health_2_reg;
  assign bus.cd_busy      = busy_v;
  assign bus.hit_pulse    = hit_reg;
  assign bus.round_state  = state_reg;
  assign bus.round_winner = winner_reg;
  assign bus.wins_1       = wins_1_reg;
  assign bus.wins_2       = wins_2_reg;
  assign bus.time_left    = time_left_reg;

endmodule
